mux_arb_n: RTL and testbench

- Parametrised N-channel, WL-bit registered select/arbitration unit; successor to the team's combinational 3:1 operand mux.
- Each channel offers a word with a valid/ready handshake. The block picks one channel per cycle by forced select, fixed priority or round-robin, and registers the chosen word with its channel index.
- Sits between the multi-cycle datapath sources (register file, ALU result, memory data) and shared consumers (ALU operand latch, writeback).

---
 rtl/mux_arb_n.sv | 180 ++++++++++++++++++
 tb/tb_mux_arb_n.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_arb_n.sv
// mux_arb_n: N-channel registered select/arbitration unit (forced, fixed-priority or round-robin).
// Define MUX_ARB_ERR_EN to add the sticky illegal-select flag sel_err and its clear input err_clr.
module mux_arb_n #(
  parameter  int WL  = 32,
  parameter  int NCH = 3,
  parameter  int CW  = 16,
  localparam int SW  = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
`ifdef MUX_ARB_ERR_EN
  input  logic              err_clr,
  output logic              sel_err,
`endif
  input  logic [NCH-1:0]    in_valid,
  input  logic [NCH*WL-1:0] in_data,
  output logic [NCH-1:0]    in_ready,
  input  logic              force_en,
  input  logic [SW-1:0]     force_sel,
  input  logic              rr_mode,
  output logic              out_valid,
  output logic [WL-1:0]     out_data,
  output logic [SW-1:0]     out_sel,
  input  logic              out_ready,
  output logic [CW-1:0]     xfer_cnt
);

  localparam logic [SW-1:0] LAST_CH = SW'(NCH - 1);

  logic              out_valid_q, out_valid_d;
  logic [WL-1:0]     out_data_q, out_data_d;
  logic [SW-1:0]     out_sel_q, out_sel_d;
  logic [CW-1:0]     xfer_cnt_q, xfer_cnt_d;
  logic [SW-1:0]     last_grant_q, last_grant_d;

  logic              sel_illegal_s;
  logic              slot_free_s;
  logic              grant_vld_s;
  logic [SW-1:0]     grant_s;
  logic [NCH-1:0]    grant_oh_s;
  logic              accept_s;
  int                rr_dist_s;
  int                rr_best_s;

  assign sel_illegal_s = force_en && (32'(force_sel) >= 32'(NCH));
  assign slot_free_s   = !out_valid_q || out_ready;

  // Grant selection: forced channel, lowest valid index, or first valid after last_grant.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_s     = '0;
    grant_oh_s  = '0;
    rr_dist_s   = 0;
    rr_best_s   = NCH;
    if (force_en) begin
      for (int i = 0; i < NCH; i++) begin
        if (!sel_illegal_s && (force_sel == SW'(i)) && in_valid[i]) begin
          grant_vld_s   = 1'b1;
          grant_s       = SW'(i);
          grant_oh_s    = '0;
          grant_oh_s[i] = 1'b1;
        end else begin
          grant_oh_s[i] = grant_oh_s[i];
        end
      end
    end else if (!rr_mode) begin
      // Descending scan so the lowest valid index is written last.
      for (int i = NCH - 1; i >= 0; i--) begin
        if (in_valid[i]) begin
          grant_vld_s   = 1'b1;
          grant_s       = SW'(i);
          grant_oh_s    = '0;
          grant_oh_s[i] = 1'b1;
        end else begin
          grant_oh_s[i] = grant_oh_s[i];
        end
      end
    end else begin
      // Distance 0 is the channel right after last_grant; nearest valid channel wins.
      for (int i = 0; i < NCH; i++) begin
        rr_dist_s = (i + NCH - int'(last_grant_q) - 1) % NCH;
        if (in_valid[i] && (rr_dist_s < rr_best_s)) begin
          rr_best_s     = rr_dist_s;
          grant_vld_s   = 1'b1;
          grant_s       = SW'(i);
          grant_oh_s    = '0;
          grant_oh_s[i] = 1'b1;
        end else begin
          rr_best_s = rr_best_s;
        end
      end
    end
  end

  // Handshake: only the granted channel sees ready, and never while reset is asserted.
  always_comb begin
    if (!rst && grant_vld_s && slot_free_s) begin
      in_ready = grant_oh_s;
    end else begin
      in_ready = '0;
    end
  end

  assign accept_s = |(in_ready & in_valid);

  // Output slot next state: load on accept, drop valid on drain, otherwise hold.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_sel_d    = out_sel_q;
    xfer_cnt_d   = xfer_cnt_q;
    last_grant_d = last_grant_q;
    if (accept_s) begin
      out_valid_d  = 1'b1;
      out_sel_d    = grant_s;
      last_grant_d = grant_s;
      xfer_cnt_d   = xfer_cnt_q + CW'(1);
      for (int i = 0; i < NCH; i++) begin
        if (grant_oh_s[i]) begin
          out_data_d = in_data[i*WL +: WL];
        end else begin
          out_data_d = out_data_d;
        end
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sel_q    <= '0;
      xfer_cnt_q   <= '0;
      last_grant_q <= LAST_CH;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sel_q    <= out_sel_d;
      xfer_cnt_q   <= xfer_cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign xfer_cnt  = xfer_cnt_q;

`ifdef MUX_ARB_ERR_EN
  logic sel_err_q, sel_err_d;

  // Sticky illegal-select flag; a same-cycle set beats err_clr.
  always_comb begin
    if (sel_illegal_s) begin
      sel_err_d = 1'b1;
    end else if (err_clr) begin
      sel_err_d = 1'b0;
    end else begin
      sel_err_d = sel_err_q;
    end
  end

  // Flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_mux_arb_n.sv
// Randomized + directed bench for mux_arb_n against a transaction-level reference model.
module tb_mux_arb_n;
  localparam int WL  = 32;
  localparam int NCH = 3;
  localparam int SW  = $clog2(NCH);
  localparam int CW  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    in_valid;
  logic [NCH*WL-1:0] in_data;
  logic [NCH-1:0]    in_ready;
  logic              force_en;
  logic [SW-1:0]     force_sel;
  logic              rr_mode;
  logic              out_valid;
  logic [WL-1:0]     out_data;
  logic [SW-1:0]     out_sel;
  logic              out_ready;
  logic [CW-1:0]     xfer_cnt;
`ifdef MUX_ARB_ERR_EN
  logic              err_clr;
  logic              sel_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit            m_valid;
  logic [WL-1:0] m_data;
  int            m_sel;
  int            m_cnt;
  int            m_last;
  bit            m_err;

  always #5 clk = ~clk;

  mux_arb_n #(.WL(WL), .NCH(NCH), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef MUX_ARB_ERR_EN
    .err_clr   (err_clr),
    .sel_err   (sel_err),
`endif
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .force_en  (force_en),
    .force_sel (force_sel),
    .rr_mode   (rr_mode),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready),
    .xfer_cnt  (xfer_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Which channel the rules grant this cycle, or -1 for none.
  function automatic int pick();
    if (force_en) begin
      if (int'(force_sel) < NCH && in_valid[force_sel]) return int'(force_sel);
      return -1;
    end
    if (!rr_mode) begin
      for (int i = 0; i < NCH; i++) if (in_valid[i]) return i;
      return -1;
    end
    for (int k = 1; k <= NCH; k++) begin
      int j = (m_last + k) % NCH;
      if (in_valid[j]) return j;
    end
    return -1;
  endfunction

  task automatic check_out();
    chk("out_valid", out_valid, m_valid);
    chk("out_data", out_data, m_data);
    chk("out_sel", out_sel, m_sel);
    chk("xfer_cnt", xfer_cnt, m_cnt);
`ifdef MUX_ARB_ERR_EN
    chk("sel_err", sel_err, m_err);
`endif
  endtask

  // Called just after a negedge with inputs already driven.
  task automatic step();
    int g;
    logic [NCH-1:0] er;
    #1;
    g  = pick();
    er = '0;
    if (g >= 0 && (!m_valid || out_ready)) er[g] = 1'b1;
    chk("in_ready", in_ready, er);
    if (|er) begin
      m_valid = 1'b1;
      m_data  = in_data[g*WL +: WL];
      m_sel   = g;
      m_last  = g;
      m_cnt   = (m_cnt + 1) % (1 << CW);
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
`ifdef MUX_ARB_ERR_EN
    if (force_en && int'(force_sel) >= NCH) m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
`endif
    @(posedge clk);
    @(negedge clk);
    check_out();
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_sel", out_sel, 2'd0);
    chk("rst_xfer_cnt", xfer_cnt, 4'd0);
    chk("rst_in_ready", in_ready, 3'b000);
`ifdef MUX_ARB_ERR_EN
    chk("rst_sel_err", sel_err, 1'b0);
`endif
    @(posedge clk);
    #1 chk("rst_in_ready_edge", in_ready, 3'b000);
    @(negedge clk);
    rst     = 1'b0;
    m_valid = 1'b0;
    m_data  = '0;
    m_sel   = 0;
    m_cnt   = 0;
    m_last  = NCH - 1;
    m_err   = 1'b0;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NCH; i++) in_data[i*WL +: WL] = $urandom;
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 3'b111;
    in_data   = '0;
    force_en  = 1'b0;
    force_sel = '0;
    rr_mode   = 1'b0;
    out_ready = 1'b0;
`ifdef MUX_ARB_ERR_EN
    err_clr   = 1'b0;
`endif
    @(negedge clk);
    do_reset();

    // Fixed priority: channel 0 always wins
    in_valid = 3'b111; out_ready = 1'b1; rr_mode = 1'b0;
    for (int k = 0; k < 5; k++) begin
      rand_data();
      step();
      chk("fixed_sel0", out_sel, 2'd0);
    end

    // Round-robin from reset: 0,1,2,0,1,2
    do_reset();
    rr_mode = 1'b1; in_valid = 3'b111; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      rand_data();
      step();
      chk("rr_seq", out_sel, k % NCH);
    end
    chk("rr_cnt6", xfer_cnt, 4'd6);

    // Forced channel 2 with a 3-cycle stall, then accept on out_ready rise
    force_en = 1'b1; force_sel = 2'd2; in_valid = 3'b100;
    in_data[2*WL +: WL] = 32'h0000_00A5;
    step();
    out_ready = 1'b0;
    in_data[2*WL +: WL] = 32'h0000_005A;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_data", out_data, 32'hA5);
    end
    out_ready = 1'b1;
    step();
    chk("reaccept_data", out_data, 32'h5A);

    // Illegal force_sel: nothing granted
    force_sel = 2'd3; in_valid = 3'b111;
    step();
    force_en = 1'b0;
    step();
`ifdef MUX_ARB_ERR_EN
    chk("sel_err_sticky", sel_err, 1'b1);
`endif

    // Counter wrap with CW=4
    do_reset();
    rr_mode = 1'b0; in_valid = 3'b111; out_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      rand_data();
      step();
      if (k == 15) chk("cnt_wrap0", xfer_cnt, 4'd0);
    end
    chk("cnt_wrap1", xfer_cnt, 4'd1);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      force_en  = ($urandom_range(0, 5) == 0);
      force_sel = SW'($urandom_range(0, 3));
      rr_mode   = ($urandom_range(0, 3) != 0);
      in_valid  = NCH'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef MUX_ARB_ERR_EN
      err_clr   = ($urandom_range(0, 15) == 0);
`endif
      rand_data();
      step();
    end

    // Reset while a word is held
`ifdef MUX_ARB_ERR_EN
    err_clr = 1'b0;
`endif
    force_en = 1'b1; force_sel = 2'd0; in_valid = 3'b001; out_ready = 1'b1;
    in_data[0 +: WL] = 32'hDEAD_BEEF;
    step();
    out_ready = 1'b0;
    step();
    chk("held_deadbeef", out_data, 32'hDEADBEEF);
    in_valid = 3'b111;
    do_reset();
    force_en = 1'b0; rr_mode = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rand_data();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
